// File: rtl/ifetch_req_unit_if.sv
// ifetch_req_unit_if: instruction-memory req/gnt/rvalid bus plus prefetch-FIFO push port
//   master (fetch unit): drives imem_req/imem_addr and out_valid/out_addr/out_instr
//   slave (memory + FIFO side): drives imem_gnt/imem_rvalid/imem_rdata
interface ifetch_req_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_addr;
  logic [XLEN-1:0] out_instr;
  modport master (
    output imem_req, imem_addr, out_valid, out_addr, out_instr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_addr, out_instr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/ifetch_req_unit.sv
// ifetch_req_unit: sequential-PC instruction fetcher feeding a prefetch FIFO, with branch squash
//   clk_i/rst_i: clock, synchronous active-high reset
//   branch_i/branch_target_i: redirect pulse and target (low two bits dropped)
//   fetch_ready_i: FIFO has room for MAX_OUTS more entries
//   bus: imem request/response and FIFO push (ifetch_req_unit_if.master)
module ifetch_req_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1000_0000,
  parameter int              MAX_OUTS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            fetch_ready_i,
  ifetch_req_unit_if.master bus
);
  localparam int PW = MAX_OUTS > 1 ? $clog2(MAX_OUTS) : 1;
  localparam int CW = $clog2(MAX_OUTS + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] addr_q [MAX_OUTS];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   outs_cnt, outs_nxt;
  logic            req_hold, req, push, pop, live;
  logic            out_valid_q;
  logic [XLEN-1:0] out_addr_q, out_instr_q;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTS - 1) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  // req_hold keeps an ungranted request up even if fetch_ready_i drops
  always_comb begin
    req       = state == FETCH && (req_hold || (fetch_ready_i && outs_cnt < CW'(MAX_OUTS)));
    push      = req && bus.imem_gnt;
    pop       = bus.imem_rvalid && outs_cnt != '0;
    live      = pop && state == FETCH && !branch_i;
    outs_nxt  = outs_cnt + CW'(push) - CW'(pop);
    state_nxt = state == IDLE  ? FETCH :
                state == FETCH ? (branch_i && outs_nxt != '0 ? DRAIN : FETCH) :
                                 (outs_nxt == '0 ? FETCH : DRAIN);
  end
  always_ff @(posedge clk_i)
    if (push) addr_q[wr_ptr] <= fetch_pc;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outs_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      req_hold    <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
    end else begin
      fetch_pc    <= branch_i ? branch_target_i & ~XLEN'(3) : push ? fetch_pc + XLEN'(4) : fetch_pc;
      outs_cnt    <= outs_nxt;
      wr_ptr      <= push ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr      <= pop ? ptr_inc(rd_ptr) : rd_ptr;
      req_hold    <= req && !bus.imem_gnt && !branch_i;
      out_valid_q <= live;
      out_addr_q  <= live ? addr_q[rd_ptr] : out_addr_q;
      out_instr_q <= live ? bus.imem_rdata : out_instr_q;
    end
  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_instr = out_instr_q;
endmodule
